// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit and receive paths: default widths,
// TX state encoding and parity-type codes.
package uart_pkg;

  localparam int DATA_WIDTH     = 8;
  localparam int PRESCALE_WIDTH = 6;

  localparam logic [2:0] TX_IDLE   = 3'd0;
  localparam logic [2:0] TX_START  = 3'd1;
  localparam logic [2:0] TX_DATA   = 3'd2;
  localparam logic [2:0] TX_PARITY = 3'd3;
  localparam logic [2:0] TX_STOP   = 3'd4;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = TX_IDLE,
    S_START  = TX_START,
    S_DATA   = TX_DATA,
    S_PARITY = TX_PARITY,
    S_STOP   = TX_STOP
  } tx_state_t;

endpackage

// File: rtl/tx_baud_counter.sv
// Edge counter (0..P-1 within a bit) plus frame bit counter. Both counters
// are held at zero by clear and only move while enable is high.
module tx_baud_counter #(
  parameter int PRESCALE_WIDTH = 6,
  parameter int BIT_W          = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_enable,
  input  logic                      i_clear,
  input  logic [PRESCALE_WIDTH-1:0] i_prescale,
  output logic                      o_bit_done,
  output logic [BIT_W-1:0]          o_bit_idx
);

  logic [PRESCALE_WIDTH-1:0] r_edge;
  logic [BIT_W-1:0]          r_bit;
  logic                      w_last_edge;

  // i_prescale is never zero here: the caller latches max(Prescale,1).
  assign w_last_edge = (r_edge == (i_prescale - PRESCALE_WIDTH'(1)));
  assign o_bit_done  = i_enable & w_last_edge;
  assign o_bit_idx   = r_bit;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_clear) begin
      r_edge <= '0;
      r_bit  <= '0;
    end else if (i_enable) begin
      if (w_last_edge) begin
        r_edge <= '0;
        r_bit  <= r_bit + BIT_W'(1);
      end else begin
        r_edge <= r_edge + PRESCALE_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_serializer.sv
// UART transmit framer: latches one word per handshake and shifts it out
// LSB-first as start, data, optional parity and stop, each bit P clocks long.
module uart_tx_frame_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = uart_pkg::DATA_WIDTH,
  parameter int PRESCALE_WIDTH = uart_pkg::PRESCALE_WIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      Data_Valid,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  output logic                      TX_OUT,
  output logic                      Busy
);

  // Frame bit index: start=0, data=1..DATA_WIDTH, then parity/stop.
  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  tx_state_t                 r_state;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic                      r_par_en;
  logic                      r_par_bit;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_tx;
  logic                      r_busy;

  logic                      w_bit_done;
  logic [BIT_W-1:0]          w_bit_idx;
  logic                      w_cnt_en;
  logic                      w_cnt_clr;
  logic [PRESCALE_WIDTH-1:0] w_prescale_eff;

  assign w_cnt_en       = (r_state != S_IDLE);
  assign w_cnt_clr      = (r_state == S_IDLE) | ((r_state == S_STOP) & w_bit_done);
  assign w_prescale_eff = (Prescale == '0) ? PRESCALE_WIDTH'(1) : Prescale;

  tx_baud_counter #(
    .PRESCALE_WIDTH (PRESCALE_WIDTH),
    .BIT_W          (BIT_W)
  ) u_baud (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_enable   (w_cnt_en),
    .i_clear    (w_cnt_clr),
    .i_prescale (r_prescale),
    .o_bit_done (w_bit_done),
    .o_bit_idx  (w_bit_idx)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_prescale <= PRESCALE_WIDTH'(1);
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_tx   <= 1'b1;
          r_busy <= 1'b0;
          if (Data_Valid) begin
            r_shift    <= P_DATA;
            r_par_en   <= PAR_EN;
            r_par_bit  <= (PAR_TYP == PAR_ODD) ? ~^P_DATA : ^P_DATA;
            r_prescale <= w_prescale_eff;
            r_state    <= S_START;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end
        S_START: begin
          if (w_bit_done) begin
            r_state <= S_DATA;
            r_tx    <= r_shift[0];
            r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
          end
        end
        S_DATA: begin
          if (w_bit_done) begin
            if (w_bit_idx == BIT_W'(DATA_WIDTH)) begin
              r_state <= r_par_en ? S_PARITY : S_STOP;
              r_tx    <= r_par_en ? r_par_bit : 1'b1;
            end else begin
              r_tx    <= r_shift[0];
              r_shift <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            end
          end
        end
        S_PARITY: begin
          if (w_bit_done) begin
            r_state <= S_STOP;
            r_tx    <= 1'b1;
          end
        end
        S_STOP: begin
          if (w_bit_done) begin
            r_state <= S_IDLE;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign TX_OUT = r_tx;
  assign Busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_frame_serializer.sv
// Scoreboard bench: stimulus pushes expected frames, a negedge monitor
// captures every Busy window and compares it against a bit-level frame model.
module tb_uart_tx_frame_serializer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       dv;
  logic       pe;
  logic       pt;
  logic [5:0] ps;
  logic       tx;
  logic       busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    int         p;
    int         gap;      // required idle cycles before this frame, -1 = any
    bit         aborted;  // frame is cut short by reset
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   frames = 0;

  uart_tx_frame_serializer dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .Data_Valid (dv),
    .PAR_EN     (pe),
    .PAR_TYP    (pt),
    .Prescale   (ps),
    .TX_OUT     (tx),
    .Busy       (busy)
  );

  always #5 clk = ~clk;

  // Reference model: value of frame bit b (0=start, 1..8 data LSB first,
  // 9 = parity when enabled, anything after = stop).
  function automatic logic frame_bit(input exp_t e, input int b);
    int ones;
    ones = $countones(e.d);
    if (b == 0) return 1'b0;
    if (b <= 8) return e.d[b-1];
    if (b == 9 && e.pe) return e.pt ? (ones % 2 == 0) : (ones % 2 == 1);
    return 1'b1;
  endfunction

  function automatic int frame_len(input exp_t e);
    return (10 + (e.pe ? 1 : 0)) * e.p;
  endfunction

  // Monitor
  bit   in_frame = 0;
  bit   cap[$];
  int   idle_cnt = 0;
  bit   idle_bad = 0;
  exp_t cur;
  int   m_len;
  int   m_mism;
  int   m_first;

  always @(negedge clk) begin
    if (!in_frame) begin
      if (busy === 1'b1) begin
        in_frame = 1;
        cap.delete();
        cap.push_back(tx);
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL spurious_frame: got a Busy window, required none");
          cur = '{d: 8'h00, pe: 1'b0, pt: 1'b0, p: 1, gap: -1, aborted: 1'b1};
        end else begin
          cur = sb.pop_front();
          if (idle_bad) begin
            bad++;
            $display("FAIL idle_line: TX_OUT got 0 while idle, required 1");
          end
        end
        if (cur.gap >= 0) begin
          total++;
          if (idle_cnt != cur.gap) begin
            bad++;
            $display("FAIL idle_gap: got %0d idle clocks, required %0d", idle_cnt, cur.gap);
          end
        end
        idle_bad = 0;
      end else begin
        idle_cnt++;
        if (tx !== 1'b1) idle_bad = 1;
      end
    end else if (busy === 1'b1) begin
      cap.push_back(tx);
    end else begin
      in_frame = 0;
      idle_cnt = 1;
      if (tx !== 1'b1) idle_bad = 1;
      frames++;
      m_len = frame_len(cur);
      total++;
      if (!cur.aborted) begin
        if (cap.size() != m_len) begin
          bad++;
          $display("FAIL frame_len: data=%h got %0d clocks, required %0d", cur.d, cap.size(), m_len);
        end
      end else if (cap.size() >= m_len) begin
        bad++;
        $display("FAIL abort_len: got %0d clocks, required fewer than %0d", cap.size(), m_len);
      end
      m_mism  = 0;
      m_first = -1;
      for (int i = 0; i < cap.size() && i < m_len; i++) begin
        if (cap[i] !== frame_bit(cur, i / cur.p)) begin
          if (m_first < 0) m_first = i;
          m_mism++;
        end
      end
      total++;
      if (m_mism != 0) begin
        bad++;
        $display("FAIL frame_bits: data=%h p=%0d got %0d wrong clocks (first at %0d, got %b), required 0",
                 cur.d, cur.p, m_mism, m_first, cap[m_first]);
      end
      $display("frame %0d: data=%h par_en=%0b par_typ=%0b p=%0d clocks=%0d aborted=%0b",
               frames, cur.d, cur.pe, cur.pt, cur.p, cap.size(), cur.aborted);
    end
  end

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic wait_level(input logic lvl, input int budget, input string what);
    int n;
    n = 0;
    while (busy !== lvl && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy !== lvl) begin
      total++;
      bad++;
      $display("FAIL timeout_%s: Busy got %b, required %b within %0d clocks", what, busy, lvl, budget);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input logic e_pe, input logic e_pt,
                              input logic [5:0] e_ps, input int gap, input bit ab);
    exp_t e;
    e.d = d; e.pe = e_pe; e.pt = e_pt;
    e.p = (e_ps == 6'd0) ? 1 : int'(e_ps);
    e.gap = gap; e.aborted = ab;
    return e;
  endfunction

  // Issue one frame; returns one clock after the accept edge.
  task automatic send(input logic [7:0] d, input logic s_pe, input logic s_pt, input logic [5:0] s_ps,
                      input bit scramble, input bit pulse, input bit ab);
    @(posedge clk); #1;
    p_data = d; pe = s_pe; pt = s_pt; ps = s_ps; dv = 1'b1;
    sb.push_back(mk(d, s_pe, s_pt, s_ps, -1, ab));
    wait_level(1'b1, 50, "accept");
    dv = 1'b0;
    if (scramble) begin
      p_data = 8'($urandom);
      pt = ~pt;
      pe = ~pe;
      ps = (s_ps == 6'd8) ? 6'd16 : 6'($urandom);
    end
    if (pulse) begin
      repeat (2) begin @(posedge clk); #1; end
      p_data = 8'h3C; dv = 1'b1;
      @(posedge clk); #1;
      dv = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic s_pe, input logic s_pt, input logic [5:0] s_ps,
                            input bit scramble, input bit pulse);
    send(d, s_pe, s_pt, s_ps, scramble, pulse, 1'b0);
    wait_level(1'b0, 2000, "frame_end");
  endtask

  // Data_Valid held across the end of frame A so frame B follows back-to-back.
  task automatic send_held(input logic [7:0] a, input logic [7:0] b, input logic b_pe,
                           input logic b_pt, input logic [5:0] a_ps, input logic [5:0] b_ps);
    @(posedge clk); #1;
    p_data = a; pe = 1'b0; pt = 1'b0; ps = a_ps; dv = 1'b1;
    sb.push_back(mk(a, 1'b0, 1'b0, a_ps, -1, 1'b0));
    wait_level(1'b1, 50, "accept_a");
    p_data = b; pe = b_pe; pt = b_pt; ps = b_ps;
    sb.push_back(mk(b, b_pe, b_pt, b_ps, 1, 1'b0));
    wait_level(1'b0, 2000, "end_a");
    wait_level(1'b1, 5, "accept_b");
    dv = 1'b0;
    wait_level(1'b0, 2000, "end_b");
  endtask

  initial begin
    int viol;
    rst = 1'b1; dv = 1'b0; p_data = 8'h00; pe = 1'b0; pt = 1'b0; ps = 6'd8;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(busy), 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    send_frame(8'hA5, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 6'd8, 1'b0, 1'b0);
    send_frame(8'h07, 1'b1, 1'b1, 6'd8, 1'b0, 1'b0);
    send_frame(8'hFF, 1'b0, 1'b0, 6'd8, 1'b0, 1'b1);
    send_held(8'hFF, 8'h3C, 1'b1, 1'b1, 6'd8, 6'd4);
    send_frame(8'h5A, 1'b1, 1'b0, 6'd8, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b0, 1'b0, 6'd16, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 6'd1, 1'b0, 1'b0);
    send_frame(8'h96, 1'b0, 1'b0, 6'd0, 1'b0, 1'b1);
    send_frame(8'h69, 1'b1, 1'b1, 6'd0, 1'b1, 1'b0);
    send_frame(8'h81, 1'b0, 1'b0, 6'd63, 1'b0, 1'b0);

    // Reset in the middle of data bit 3 of a P=8 frame.
    send(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0, 1'b0, 1'b1);
    repeat (34) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(busy), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    viol = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx !== 1'b1 || busy !== 1'b0) viol++;
    end
    check("post_reset_quiet", viol, 0);

    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 3) == 0)
        send_held(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  6'($urandom_range(0, 12)), 6'($urandom_range(0, 12)));
      else
        send_frame(8'($urandom), 1'($urandom), 1'($urandom), 6'($urandom_range(0, 12)),
                   1'($urandom), 1'($urandom));
    end

    repeat (20) @(posedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
